// File: rtl/toy_pack.sv
// toy_pack: shared types and constants for the custom-instruction dispatch path.
//   custom_inst_t        : one custom instruction as issued by toy_core
//   ch_width()           : width of a channel index for a given channel count (min 1)
//   CUSTOM_DISPATCH_CH_W : channel index width for the default 4-channel build
package toy_pack;

    localparam int INST_WIDTH = 32;
    localparam int REG_WIDTH  = 32;
    localparam int ADDR_WIDTH = 32;

    localparam int CUSTOM_DISPATCH_NUM_CH = 4;

    typedef struct packed {
        logic [INST_WIDTH-1:0] pld;
        logic [REG_WIDTH-1:0]  rs1_val;
        logic [REG_WIDTH-1:0]  rs2_val;
        logic [ADDR_WIDTH-1:0] pc;
    } custom_inst_t;

    // A single-channel build still needs a 1-bit index so ports never collapse to zero width.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    localparam int CUSTOM_DISPATCH_CH_W = ch_width(CUSTOM_DISPATCH_NUM_CH);

endpackage

// File: rtl/toy_custom_fifo.sv
// toy_custom_fifo: DEPTH-entry synchronous FIFO of custom instructions tagged with
// their decoded channel.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush_i               : synchronous clear of all entries
//   push_i, push_inst_i,
//   push_ch_i             : write one entry (ignored when full or flushing)
//   pop_i                 : drop the head entry (ignored when empty or flushing)
//   head_inst_o, head_ch_o: current head entry (valid when !empty_o)
//   full_o, empty_o       : status
module toy_custom_fifo
    import toy_pack::*;
#(
    parameter int DEPTH = 4,
    parameter int CH_W  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                push_i,
    input  custom_inst_t        push_inst_i,
    input  logic [CH_W-1:0]     push_ch_i,
    input  logic                pop_i,
    output custom_inst_t        head_inst_o,
    output logic [CH_W-1:0]     head_ch_o,
    output logic                full_o,
    output logic                empty_o
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        custom_inst_t    inst;
        logic [CH_W-1:0] ch;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one wrap bit: equal indices mean empty when the wrap bits
    // match and full when they differ.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    assign head_inst_o = mem_q[rd_ptr_q[AW-1:0]].inst;
    assign head_ch_o   = mem_q[rd_ptr_q[AW-1:0]].ch;

    assign wr_ptr_d = flush_i ? '0 : (do_push ? wr_ptr_q + 1'b1 : wr_ptr_q);
    assign rd_ptr_d = flush_i ? '0 : (do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q);

    // NOTE: state registers use non-blocking assignments so every flop samples
    //       pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers define
    //       which entries are meaningful, so resetting data only costs routing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{inst: push_inst_i, ch: push_ch_i};
        end
    end

endmodule

// File: rtl/toy_custom_dispatch.sv
// toy_custom_dispatch: buffers custom instructions from toy_core in order and
// presents each one on the coprocessor channel selected by its instruction word.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous discard of everything held
//   in_vld/in_rdy     : input handshake; in_pld/in_rs1_val/in_rs2_val/in_pc payload
//   out_vld/out_rdy   : per-channel handshake (out_vld is one-hot)
//   out_pld/out_rs1_val/out_rs2_val/out_pc : payload broadcast to all channels
//   occupancy         : instructions held (FIFO plus output register)
//   err_timeout/err_ch: one-cycle pulse and channel of a stall-dropped instruction
// Optional macro TOY_CUSTOM_DISPATCH_TIMEOUT_EN enables the stall timeout; without
// it err_timeout and err_ch are constant 0.
module toy_custom_dispatch
    import toy_pack::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DEPTH          = 4,
    parameter int CH_SEL_LSB     = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic [INST_WIDTH-1:0]         in_pld,
    input  logic [REG_WIDTH-1:0]          in_rs1_val,
    input  logic [REG_WIDTH-1:0]          in_rs2_val,
    input  logic [ADDR_WIDTH-1:0]         in_pc,
    output logic [NUM_CH-1:0]             out_vld,
    input  logic [NUM_CH-1:0]             out_rdy,
    output logic [INST_WIDTH-1:0]         out_pld,
    output logic [REG_WIDTH-1:0]          out_rs1_val,
    output logic [REG_WIDTH-1:0]          out_rs2_val,
    output logic [ADDR_WIDTH-1:0]         out_pc,
    output logic [$clog2(DEPTH+2)-1:0]    occupancy,
    output logic                          err_timeout,
    output logic [ch_width(NUM_CH)-1:0]   err_ch
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int OCC_W = $clog2(DEPTH+2);

    custom_inst_t    in_inst;
    logic [CH_W-1:0] in_ch;
    logic            accept;
    logic            xfer;
    logic            drop;
    logic            out_free;

    custom_inst_t    fifo_head_inst;
    logic [CH_W-1:0] fifo_head_ch;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;

    logic            out_valid_q, out_valid_d;
    custom_inst_t    out_inst_q, out_inst_d;
    logic [CH_W-1:0] out_ch_q, out_ch_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    assign in_inst = '{pld: in_pld, rs1_val: in_rs1_val, rs2_val: in_rs2_val, pc: in_pc};

    if (NUM_CH > 1) begin : g_ch_sel
        assign in_ch = in_pld[CH_SEL_LSB +: CH_W];
    end else begin : g_ch_zero
        assign in_ch = '0;
    end

    // in_rdy looks only at FIFO fullness, never at out_rdy, so there is no
    // combinational path from the coprocessors back to the core.
    assign in_rdy = !fifo_full && !flush;
    assign accept = in_vld && in_rdy;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            out_vld[i] = out_valid_q && (out_ch_q == CH_W'(i));
        end
    end

    assign xfer     = |(out_vld & out_rdy);
    // The output slot can take a new entry when it is empty, its entry leaves
    // this cycle, or its entry is being dropped for stalling.
    assign out_free = !out_valid_q || xfer || drop;

    // NOTE: every combinational output gets a default first so no path can
    //       leave a signal unassigned and infer a latch.
    always_comb begin
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_ch_d    = out_ch_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (out_free) begin
            if (!fifo_empty) begin
                out_valid_d = 1'b1;
                out_inst_d  = fifo_head_inst;
                out_ch_d    = fifo_head_ch;
                fifo_pop    = 1'b1;
                fifo_push   = accept;
            end else if (accept) begin
                // Bypass: empty FIFO, the accepted instruction goes straight out.
                out_valid_d = 1'b1;
                out_inst_d  = in_inst;
                out_ch_d    = in_ch;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            fifo_push = accept;
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(accept) - OCC_W'(xfer || drop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_ch_q    <= '0;
            occ_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_ch_q    <= out_ch_d;
            occ_q       <= occ_d;
        end
    end

    assign out_pld     = out_inst_q.pld;
    assign out_rs1_val = out_inst_q.rs1_val;
    assign out_rs2_val = out_inst_q.rs2_val;
    assign out_pc      = out_inst_q.pc;
    assign occupancy   = occ_q;

`ifdef TOY_CUSTOM_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             err_timeout_q;
    logic [CH_W-1:0]  err_ch_q;

    assign drop        = out_valid_q && !xfer && (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES-1));
    // Any change of the output slot (transfer, load, drop) or a flush restarts the count.
    assign stall_cnt_d = (flush || out_free) ? '0 : stall_cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q   <= '0;
            err_timeout_q <= 1'b0;
            err_ch_q      <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            err_timeout_q <= drop && !flush;
            if (drop && !flush) begin
                err_ch_q <= out_ch_q;
            end
        end
    end

    assign err_timeout = err_timeout_q;
    assign err_ch      = err_ch_q;
`else
    assign drop        = 1'b0;
    assign err_timeout = 1'b0;
    assign err_ch      = '0;
`endif

    toy_custom_fifo #(
        .DEPTH (DEPTH),
        .CH_W  (CH_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .push_i      (fifo_push),
        .push_inst_i (in_inst),
        .push_ch_i   (in_ch),
        .pop_i       (fifo_pop),
        .head_inst_o (fifo_head_inst),
        .head_ch_o   (fifo_head_ch),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_toy_custom_dispatch.sv
// Self-checking bench for toy_custom_dispatch (NUM_CH=4, DEPTH=4, TIMEOUT_CYCLES=16).
// Directed table of per-cycle expectations, hand sequences for reset and timeout,
// then random traffic against a queue-based reference model.
module tb_toy_custom_dispatch;
    import toy_pack::*;

    localparam int NUM_CH         = 4;
    localparam int DEPTH          = 4;
    localparam int CH_SEL_LSB     = 12;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int OCC_W          = $clog2(DEPTH+2);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  flush = 1'b0;
    logic                  in_vld = 1'b0;
    logic                  in_rdy;
    logic [INST_WIDTH-1:0] in_pld = '0;
    logic [REG_WIDTH-1:0]  in_rs1_val = '0;
    logic [REG_WIDTH-1:0]  in_rs2_val = '0;
    logic [ADDR_WIDTH-1:0] in_pc = '0;
    logic [NUM_CH-1:0]     out_vld;
    logic [NUM_CH-1:0]     out_rdy = '0;
    logic [INST_WIDTH-1:0] out_pld;
    logic [REG_WIDTH-1:0]  out_rs1_val;
    logic [REG_WIDTH-1:0]  out_rs2_val;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [OCC_W-1:0]      occupancy;
    logic                  err_timeout;
    logic [1:0]            err_ch;

    toy_custom_dispatch #(
        .NUM_CH         (NUM_CH),
        .DEPTH          (DEPTH),
        .CH_SEL_LSB     (CH_SEL_LSB),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .in_pld      (in_pld),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_val  (in_rs2_val),
        .in_pc       (in_pc),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_pld     (out_pld),
        .out_rs1_val (out_rs1_val),
        .out_rs2_val (out_rs2_val),
        .out_pc      (out_pc),
        .occupancy   (occupancy),
        .err_timeout (err_timeout),
        .err_ch      (err_ch)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic custom_inst_t mk(input int ch, input int tag);
        custom_inst_t r;
        r.pld     = 32'h0000_000B | (32'(ch) << CH_SEL_LSB) | (32'(tag) << 20);
        r.rs1_val = 32'h1000_0000 + 32'(tag);
        r.rs2_val = 32'h2000_0000 + 32'(tag);
        r.pc      = 32'h8000_0000 + 32'(tag * 4);
        return r;
    endfunction

    // ---------------- reference model: an ordered list of held instructions ----------------
    typedef struct {
        custom_inst_t d;
        int           ch;
    } m_entry_t;

    m_entry_t mq[$];
    int       m_stall  = 0;
    logic     m_err    = 1'b0;
    int       m_err_ch = 0;

    task automatic model_reset();
        mq.delete();
        m_stall  = 0;
        m_err    = 1'b0;
        m_err_ch = 0;
    endtask

    task automatic check_model();
        logic [3:0] ev;
        ev = (mq.size() > 0) ? 4'(1 << mq[0].ch) : 4'b0000;
        check("out_vld", out_vld, ev);
        check("occupancy", occupancy, mq.size());
        check("in_rdy", in_rdy, (mq.size() <= DEPTH) && !flush);
        check("err_timeout", err_timeout, m_err);
        check("err_ch", err_ch, m_err_ch);
        if (mq.size() > 0) begin
            check("out_pld", out_pld, mq[0].d.pld);
            check("out_rs1_val", out_rs1_val, mq[0].d.rs1_val);
            check("out_rs2_val", out_rs2_val, mq[0].d.rs2_val);
            check("out_pc", out_pc, mq[0].d.pc);
        end
    endtask

    // Applies one clock edge to the model using the inputs the bench is driving.
    task automatic model_step();
        bit       pres, acc, xf, dr;
        m_entry_t e;
        pres = (mq.size() > 0);
        acc  = in_vld && (mq.size() <= DEPTH) && !flush;
        xf   = pres ? out_rdy[mq[0].ch] : 1'b0;
        dr   = 1'b0;
`ifdef TOY_CUSTOM_DISPATCH_TIMEOUT_EN
        dr   = pres && !xf && (m_stall == TIMEOUT_CYCLES - 1);
`endif
        m_err = dr && !flush;
        if (dr && !flush) m_err_ch = mq[0].ch;
        m_stall = (pres && !xf && !dr && !flush) ? m_stall + 1 : 0;
        if (flush) begin
            mq.delete();
        end else begin
            if (xf || dr) void'(mq.pop_front());
            if (acc) begin
                e.d  = '{pld: in_pld, rs1_val: in_rs1_val, rs2_val: in_rs2_val, pc: in_pc};
                e.ch = int'(in_pld[CH_SEL_LSB +: 2]);
                mq.push_back(e);
            end
        end
    endtask

    // ---------------- cycle drivers ----------------
    task automatic drive(input logic v, input custom_inst_t d, input logic [3:0] rdy, input logic fl);
        @(negedge clk);
        in_vld     = v;
        in_pld     = d.pld;
        in_rs1_val = d.rs1_val;
        in_rs2_val = d.rs2_val;
        in_pc      = d.pc;
        out_rdy    = rdy;
        flush      = fl;
        #1;
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        cyc++;
    endtask

    task automatic cycle(input logic v, input custom_inst_t d, input logic [3:0] rdy, input logic fl);
        drive(v, d, rdy, fl);
        advance();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_vld"}, out_vld, 4'b0000);
        check({tag, "_occupancy"}, occupancy, 0);
        check({tag, "_out_pld"}, out_pld, 0);
        check({tag, "_out_rs1"}, out_rs1_val, 0);
        check({tag, "_out_rs2"}, out_rs2_val, 0);
        check({tag, "_out_pc"}, out_pc, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
        check({tag, "_err_ch"}, err_ch, 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       vld;
        int         ch;
        logic [3:0] rdy;
        logic       fl;
        logic       e_rdy;
        logic [3:0] e_vld;
        int         e_occ;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic vld, input int ch, input logic [3:0] rdy, input logic fl,
                     input logic e_rdy, input logic [3:0] e_vld, input int e_occ);
        vec_t r;
        r.vld = vld; r.ch = ch; r.rdy = rdy; r.fl = fl;
        r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_occ = e_occ;
        vecs.push_back(r);
    endtask

    initial begin
        custom_inst_t idle;
        int rise;
        int hit;
        idle = '0;

        // Expectations are what the DUT shows during that cycle, before its edge.
        // bypass latency
        v(0, 0, 4'hF, 0, 1, 4'b0000, 0);
        v(1, 2, 4'hF, 0, 1, 4'b0000, 0);
        v(0, 0, 4'hF, 0, 1, 4'b0100, 1);
        v(0, 0, 4'hF, 0, 1, 4'b0000, 0);
        // back-pressure fill: six pushes, five fit
        v(1, 0, 4'h0, 0, 1, 4'b0000, 0);
        v(1, 1, 4'h0, 0, 1, 4'b0001, 1);
        v(1, 2, 4'h0, 0, 1, 4'b0001, 2);
        v(1, 3, 4'h0, 0, 1, 4'b0001, 3);
        v(1, 0, 4'h0, 0, 1, 4'b0001, 4);
        v(1, 1, 4'h0, 0, 0, 4'b0001, 5);
        v(0, 0, 4'hF, 0, 0, 4'b0001, 5);
        v(0, 0, 4'hF, 0, 1, 4'b0010, 4);
        v(0, 0, 4'hF, 0, 1, 4'b0100, 3);
        v(0, 0, 4'hF, 0, 1, 4'b1000, 2);
        v(0, 0, 4'hF, 0, 1, 4'b0001, 1);
        v(0, 0, 4'hF, 0, 1, 4'b0000, 0);
        // head-of-line blocking
        v(1, 1, 4'h1, 0, 1, 4'b0000, 0);
        v(1, 0, 4'h1, 0, 1, 4'b0010, 1);
        v(0, 0, 4'h1, 0, 1, 4'b0010, 2);
        v(0, 0, 4'h1, 0, 1, 4'b0010, 2);
        v(0, 0, 4'h2, 0, 1, 4'b0010, 2);
        v(0, 0, 4'h1, 0, 1, 4'b0001, 1);
        v(0, 0, 4'hF, 0, 1, 4'b0000, 0);
        // flush with three held, then a fresh push
        v(1, 0, 4'h0, 0, 1, 4'b0000, 0);
        v(1, 1, 4'h0, 0, 1, 4'b0001, 1);
        v(1, 2, 4'h0, 0, 1, 4'b0001, 2);
        v(0, 0, 4'h0, 1, 0, 4'b0001, 3);
        v(1, 3, 4'hF, 0, 1, 4'b0000, 0);
        v(0, 0, 4'hF, 0, 1, 4'b1000, 1);
        v(0, 0, 4'hF, 0, 1, 4'b0000, 0);
        // flush coinciding with a transfer and an input attempt
        v(1, 2, 4'hF, 0, 1, 4'b0000, 0);
        v(1, 1, 4'hF, 1, 0, 4'b0100, 1);
        v(0, 0, 4'hF, 0, 1, 4'b0000, 0);

        // reset state
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].vld, mk(vecs[i].ch, i), vecs[i].rdy, vecs[i].fl);
            check($sformatf("tbl%0d_in_rdy", i), in_rdy, vecs[i].e_rdy);
            check($sformatf("tbl%0d_out_vld", i), out_vld, vecs[i].e_vld);
            check($sformatf("tbl%0d_occupancy", i), occupancy, vecs[i].e_occ);
            advance();
        end

        // reset in the middle of operation
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(i, 40 + i), 4'h0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        in_vld = 1'b0;
        drive(1'b0, idle, 4'hF, 1'b0);
        check("post_reset_in_rdy", in_rdy, 1);
        check("post_reset_occ", occupancy, 0);
        advance();
        cycle(1'b1, mk(2, 60), 4'hF, 1'b0);
        drive(1'b0, idle, 4'hF, 1'b0);
        check("post_reset_vld", out_vld, 4'b0100);
        check("post_reset_pld", out_pld, 32'h03C0_200B);
        advance();
        cycle(1'b0, idle, 4'hF, 1'b0);

`ifdef TOY_CUSTOM_DISPATCH_TIMEOUT_EN
        // stall timeout on channel 3, channel 1 waiting behind it
        rise = -1;
        hit  = -1;
        cycle(1'b1, mk(3, 50), 4'h0, 1'b0);
        drive(1'b1, mk(1, 51), 4'h0, 1'b0);
        if (out_vld != 4'b0000) rise = cyc;
        advance();
        for (int k = 0; k < 40 && hit < 0; k++) begin
            drive(1'b0, idle, 4'h0, 1'b0);
            if (err_timeout === 1'b1) begin
                hit = cyc;
                check("to_next_vld", out_vld, 4'b0010);
                check("to_err_ch", err_ch, 3);
            end
            advance();
        end
        check("to_latency", (rise < 0 || hit < 0) ? -1 : hit - rise, 16);
        drive(1'b0, idle, 4'h0, 1'b0);
        check("to_pulse_one_cycle", err_timeout, 0);
        advance();
        cycle(1'b0, idle, 4'h0, 1'b1);
`endif

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            custom_inst_t d;
            logic [3:0]   rdy;
            d.pld     = $urandom;
            d.rs1_val = $urandom;
            d.rs2_val = $urandom;
            d.pc      = $urandom;
            rdy       = ((i / 40) % 2 == 1) ? 4'($urandom_range(0, 15) & 4'h5) : 4'($urandom_range(0, 15));
            cycle(($urandom_range(0, 3) != 0), d, rdy, ($urandom_range(0, 24) == 0));
        end
        cycle(1'b0, idle, 4'hF, 1'b1);
        cycle(1'b0, idle, 4'hF, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
